// File: rtl/fp_pkg.sv
// Shared types and constants for the Q7.8 sequential divider.
package fp_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;
    localparam int N_ITER = DATA_W + FRAC_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    localparam logic [DATA_W-1:0] FP_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] FP_MIN = 16'h8000;
    localparam logic [DATA_W-1:0] FP_ONE = 16'h0100;

    // Flag vector in the same layout as the ALU; carry is never set by division.
    function automatic logic [3:0] pack_flags(input logic [DATA_W-1:0] res, input logic ovf);
        logic [3:0] f;
        f         = '0;
        f[FLAG_C] = 1'b0;
        f[FLAG_Z] = (res == '0);
        f[FLAG_N] = res[DATA_W-1];
        f[FLAG_V] = ovf;
        return f;
    endfunction

endpackage

// File: rtl/fp_div_seq_if.sv
// Request/response handshake bundle between the divider and its user.
interface fp_div_seq_if;
    import fp_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic [3:0]        flags;

    modport master (
        output in_valid, data_a, data_b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, data_a, data_b, out_ready,
        output in_ready, out_valid, result, flags
    );

endinterface

// File: rtl/two_complement.sv
// Two's complement negation; the most negative value maps onto itself.
module two_complement #(
    parameter int N = 16
) (
    input  logic [N-1:0] i_a,
    output logic [N-1:0] o_y
);

    assign o_y = ~i_a + N'(1);

endmodule

// File: rtl/fp_div_seq.sv
// Sequential signed Q7.8 divider: restoring division on magnitudes,
// one quotient bit per cycle, sign and saturation applied at the end.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | one restoring iteration per cycle, counter counts down to 0
// DONE  | result/flags held, out_valid high until out_ready
module fp_div_seq
    import fp_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    fp_div_seq_if.slave  bus
);

    state_t              r_state;
    state_t              w_next;

    logic                r_sign;
    logic [DATA_W-1:0]   r_mag_b;
    logic [N_ITER-1:0]   r_dvd;
    logic [DATA_W:0]     r_rem;
    logic [4:0]          r_cnt;
    logic [DATA_W-1:0]   r_result;
    logic [3:0]          r_flags;

    logic [DATA_W-1:0]   w_neg_a;
    logic [DATA_W-1:0]   w_neg_b;
    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic [DATA_W-1:0]   w_neg_q;
    logic                w_accept;
    logic                w_b_zero;
    logic [DATA_W-1:0]   w_dz_res;
    logic [DATA_W+1:0]   w_rem_sh;
    logic [DATA_W+1:0]   w_diff;
    logic                w_qbit;
    logic [N_ITER-1:0]   w_q_next;
    logic [DATA_W-1:0]   w_fin_res;
    logic                w_fin_ovf;

    two_complement #(.N(DATA_W)) u_neg_a (.i_a(bus.data_a),          .o_y(w_neg_a));
    two_complement #(.N(DATA_W)) u_neg_b (.i_a(bus.data_b),          .o_y(w_neg_b));
    two_complement #(.N(DATA_W)) u_neg_q (.i_a(w_q_next[DATA_W-1:0]), .o_y(w_neg_q));

    assign w_mag_a  = bus.data_a[DATA_W-1] ? w_neg_a : bus.data_a;
    assign w_mag_b  = bus.data_b[DATA_W-1] ? w_neg_b : bus.data_b;
    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_b_zero = (bus.data_b == '0);
    assign w_dz_res = bus.data_a[DATA_W-1] ? FP_MIN : FP_MAX;

    // Restoring step: bring in the next dividend bit, keep the difference if non-negative.
    assign w_rem_sh = {1'b0, r_rem, r_dvd[N_ITER-1]};
    assign w_diff   = w_rem_sh - {2'b00, r_mag_b};
    assign w_qbit   = ~w_diff[DATA_W+1];
    assign w_q_next = {r_dvd[N_ITER-2:0], w_qbit};

    // Sign application and saturation of the completed quotient magnitude.
    always_comb begin
        w_fin_res = w_q_next[DATA_W-1:0];
        w_fin_ovf = 1'b0;
        if (!r_sign) begin
            if (w_q_next > N_ITER'(FP_MAX)) begin
                w_fin_res = FP_MAX;
                w_fin_ovf = 1'b1;
            end
        end else if (w_q_next > N_ITER'(FP_MIN)) begin
            w_fin_res = FP_MIN;
            w_fin_ovf = 1'b1;
        end else begin
            w_fin_res = w_neg_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next        = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_next = w_b_zero ? DONE : CALC;
            end
            CALC: begin
                if (r_cnt == 5'd1) w_next = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign   <= 1'b0;
            r_mag_b  <= '0;
            r_dvd    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_accept) begin
            r_sign  <= bus.data_a[DATA_W-1] ^ bus.data_b[DATA_W-1];
            r_mag_b <= w_mag_b;
            r_dvd   <= {w_mag_a, {FRAC_W{1'b0}}};
            r_rem   <= '0;
            if (w_b_zero) begin
                r_cnt    <= '0;
                r_result <= w_dz_res;
                r_flags  <= pack_flags(w_dz_res, 1'b1);
            end else begin
                r_cnt <= 5'(N_ITER);
            end
        end else if (r_state == CALC) begin
            r_rem <= w_qbit ? w_diff[DATA_W:0] : w_rem_sh[DATA_W:0];
            r_dvd <= w_q_next;
            r_cnt <= r_cnt - 5'd1;
            if (r_cnt == 5'd1) begin
                r_result <= w_fin_res;
                r_flags  <= pack_flags(w_fin_res, w_fin_ovf);
            end
        end
    end

    assign bus.result = r_result;
    assign bus.flags  = r_flags;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for the Q7.8 sequential divider.
module tb_fp_div_seq;
    import fp_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    fp_div_seq_if bus();

    fp_div_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_res;
        logic [3:0]  exp_flags;
        int          exp_lat;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present operands, accept them, and return the latency to out_valid
    // counted in clock edges from the accept edge inclusive (0 on timeout).
    task automatic start_div(input logic [15:0] a, input logic [15:0] b, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.data_a   = a;
        bus.data_b   = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.data_a   = ~a;
        bus.data_b   = 16'h0001;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.out_valid) lat = 0;
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("release_out_valid", 32'(bus.out_valid), 32'd0);
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic [15:0] held_res;
        logic [3:0]  held_flags;

        n_chk = 0;
        n_err = 0;
        vecs[0]  = '{16'h0300, 16'h0200, 16'h0180, 4'b0000, 25};
        vecs[1]  = '{16'hFF00, 16'h0400, 16'hFFC0, 4'b0100, 25};
        vecs[2]  = '{16'h0100, 16'h0300, 16'h0055, 4'b0000, 25};
        vecs[3]  = '{16'h0100, 16'h0000, 16'h7FFF, 4'b1000, 1};
        vecs[4]  = '{16'h8000, 16'h0000, 16'h8000, 4'b1100, 1};
        vecs[5]  = '{16'h7F00, 16'h0001, 16'h7FFF, 4'b1000, 25};
        vecs[6]  = '{16'h0000, 16'hFF00, 16'h0000, 4'b0010, 25};
        vecs[7]  = '{16'h8000, 16'hFF00, 16'h7FFF, 4'b1000, 25};
        vecs[8]  = '{16'h8000, 16'h0100, 16'h8000, 4'b0100, 25};
        vecs[9]  = '{16'hFFFF, 16'h0200, 16'h0000, 4'b0010, 25};
        vecs[10] = '{16'hFD00, 16'hFE00, 16'h0180, 4'b0000, 25};
        vecs[11] = '{16'h0300, 16'hFE00, 16'hFE80, 4'b0100, 25};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data_a    = '0;
        bus.data_b    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_result", 32'(bus.result), 32'd0);
        chk("reset_flags", 32'(bus.flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            start_div(vecs[i].a, vecs[i].b, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_result", i), 32'(bus.result), 32'(vecs[i].exp_res));
            chk($sformatf("vec%0d_flags", i), 32'(bus.flags), 32'(vecs[i].exp_flags));
            release_result();
        end

        // Backpressure: result held, no accept while DONE, including the release edge.
        start_div(16'h0300, 16'h0200, lat);
        chk("bp_latency", 32'(lat), 32'd25);
        held_res   = 16'h0180;
        held_flags = 4'b0000;
        bus.data_a   = 16'h0100;
        bus.data_b   = 16'h0000;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_result", 32'(bus.result), 32'(held_res));
            chk("bp_flags", 32'(bus.flags), 32'(held_flags));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_release_result", 32'(bus.result), 32'(held_res));

        // Reset mid-CALC: discarded operation, clean restart.
        @(negedge clk);
        bus.data_a   = 16'h7F00;
        bus.data_b   = 16'h0001;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midcalc_in_ready_busy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_result", 32'(bus.result), 32'd0);
        chk("midrst_flags", 32'(bus.flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            chk("postrst_no_out_valid", 32'(bus.out_valid), 32'd0);
        end
        start_div(16'h0300, 16'h0200, lat);
        chk("postrst_latency", 32'(lat), 32'd25);
        chk("postrst_result", 32'(bus.result), 32'h0180);
        chk("postrst_flags", 32'(bus.flags), 32'h0);
        release_result();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
